// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry front end.
// CALC_MUL_EN widens the set of accepted operator keys to include KEY_MUL.
package calc_pkg;

  typedef enum logic [1:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [7:0] KEY_ADD = 8'd10;
  localparam logic [7:0] KEY_SUB = 8'd11;
  localparam logic [7:0] KEY_MUL = 8'd12;
  localparam logic [7:0] KEY_EQ  = 8'd13;
  localparam logic [7:0] KEY_CLR = 8'd14;

  localparam logic [7:0] OP_NONE = 8'd128;
  localparam logic [7:0] OP_SUB  = 8'd130;
  localparam logic [7:0] OP_ADD  = 8'd131;
  localparam logic [7:0] OP_MUL  = 8'd132;

  function automatic logic is_op_key(input logic [7:0] k);
`ifdef CALC_MUL_EN
    return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
`else
    return (k == KEY_ADD) || (k == KEY_SUB);
`endif
  endfunction

  function automatic logic [7:0] op_glyph(input logic [7:0] k);
    case (k)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/seq_mult8.sv
// 8x8 shift-add multiplier: loads on start, runs 8 iterations on a down-counter,
// pulses done together with the final product. abort drops an in-flight operation.
module seq_mult8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic [15:0] product,
  output logic        done
);

  logic [15:0] mcand_q;
  logic [7:0]  mplier_q;
  logic [15:0] acc_q;
  logic [3:0]  cnt_q;
  logic        done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        cnt_q <= '0;
      end else if (start) begin
        mcand_q  <= {8'd0, mcand};
        mplier_q <= mplier;
        acc_q    <= '0;
        cnt_q    <= 4'd8;
      end else if (cnt_q != 4'd0) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 4'd1;
        // terminal count: the accumulate above is the last one
        if (cnt_q == 4'd1) done_q <= 1'b1;
      end
    end
  end

  assign product = acc_q;
  assign done    = done_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad calculator front end: builds operands A/B and an operator, computes on '='.
// Define CALC_MUL_EN to accept KEY_MUL and build the seq_mult8 multiplier.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_ENTER_A | collecting digits of A, waiting for an operator
// S_ENTER_B | collecting digits of B; '=' arms eq_pend_q for one cycle
// S_CALC    | busy: add/sub settle in one cycle, multiply waits for done
// S_DONE    | result shown; digit restarts, operator chains on result
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned MAX_VAL = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] operand,
  output logic [7:0] result,
  output logic       sign,
  output logic       overflow,
  output logic       busy
);

  state_t     state_q;
  logic [7:0] a_q, b_q, op_q, res_q;
  logic       sign_q, ovf_q, busy_q, b_dig_q, eq_pend_q;

  logic       key_clr, key_eq, key_dig, key_op;
  logic [3:0] digit;
  logic [11:0] a_ext, b_ext;
  logic [7:0] a_d, b_d, diff_d;
  logic [8:0] sum_d;

  always_comb begin
    key_clr = key_valid && (key_code == KEY_CLR);
    key_eq  = key_valid && (key_code == KEY_EQ);
    key_dig = key_valid && (key_code <= 8'd9);
    key_op  = key_valid && is_op_key(key_code);
    digit   = key_code[3:0];
    a_ext   = 12'(a_q) * 12'd10 + 12'(digit);
    b_ext   = 12'(b_q) * 12'd10 + 12'(digit);
    a_d     = (a_ext > 12'(MAX_VAL)) ? a_q : a_ext[7:0];
    b_d     = (b_ext > 12'(MAX_VAL)) ? b_q : b_ext[7:0];
    sum_d   = 9'(a_q) + 9'(b_q);
    diff_d  = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
  end

`ifdef CALC_MUL_EN
  logic [15:0] prod;
  logic        mul_done;

  // multiplier loads on the edge that enters S_CALC
  seq_mult8 u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (eq_pend_q && (op_q == OP_MUL)),
    .abort   (key_clr),
    .mcand   (a_q),
    .mplier  (b_q),
    .product (prod),
    .done    (mul_done)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_NONE;
      res_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      b_dig_q   <= 1'b0;
      eq_pend_q <= 1'b0;
    end else if (key_clr) begin
      state_q   <= S_ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_NONE;
      res_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      b_dig_q   <= 1'b0;
      eq_pend_q <= 1'b0;
    end else begin
      case (state_q)
        S_ENTER_A: begin
          if (key_dig) begin
            a_q <= a_d;
          end else if (key_op) begin
            op_q    <= op_glyph(key_code);
            b_q     <= '0;
            b_dig_q <= 1'b0;
            state_q <= S_ENTER_B;
          end
        end
        S_ENTER_B: begin
          if (eq_pend_q) begin
            eq_pend_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_CALC;
          end else if (key_dig) begin
            b_q     <= b_d;
            b_dig_q <= 1'b1;
          end else if (key_op && !b_dig_q) begin
            op_q <= op_glyph(key_code);
          end else if (key_eq) begin
            eq_pend_q <= 1'b1;
          end
        end
        S_CALC: begin
          if (op_q == OP_SUB) begin
            res_q   <= diff_d;
            sign_q  <= (a_q < b_q);
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
`ifdef CALC_MUL_EN
          end else if (op_q == OP_MUL) begin
            if (mul_done) begin
              res_q   <= prod[7:0];
              ovf_q   <= |prod[15:8];
              sign_q  <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
`endif
          end else begin
            res_q   <= sum_d[7:0];
            ovf_q   <= sum_d[8];
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (key_dig) begin
            a_q     <= 8'(digit);
            b_q     <= '0;
            op_q    <= OP_NONE;
            res_q   <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= S_ENTER_A;
          end else if (key_op && !sign_q && !ovf_q) begin
            // chain: the unsigned, in-range result becomes the next A
            a_q     <= res_q;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= op_glyph(key_code);
            b_dig_q <= 1'b0;
            state_q <= S_ENTER_B;
          end
        end
      endcase
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign operand  = op_q;
  assign result   = res_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keypad-driven calculator front end that sits directly upstream of the VGA display top. It takes decoded key events, builds two 8-bit decimal operands and an operator, and computes the result on `=`. It drives `a`, `b`, `operand`, `result`, `sign` and `overflow` straight into the display inputs. Add and subtract take one cycle; multiply uses an 8-cycle shift-add sequencer.

## Interface
Parameters:
- `MAX_VAL`, default 255: largest enterable operand value.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `key_code`, input, 8: decoded key. Digits are 0..9. Other keys are `KEY_ADD`, `KEY_SUB`, `KEY_MUL`, `KEY_EQ`, `KEY_CLR`.
- `key_valid`, input, 1: single-cycle strobe qualifying `key_code`.
- `a`, output, 8: operand A, binary.
- `b`, output, 8: operand B, binary.
- `operand`, output, 8: operator glyph code (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_NONE`).
- `result`, output, 8: magnitude of the result.
- `sign`, output, 1: 1 means the result is negative.
- `overflow`, output, 1: 1 means the true result exceeds 255.
- `busy`, output, 1: high while in CALC.

## Operation
- All outputs are registered.
- Reset value of every output is 0, except `operand`, which resets to `OP_NONE`. State resets to ENTER_A.
- States: ENTER_A, ENTER_B, CALC, DONE.
- Digit entry: the new value is old×10 + digit. If the new value would exceed `MAX_VAL`, the digit is dropped and the value is kept.
- ENTER_A:
  - Digit → updates `a`.
  - Operator key → latch the operator into `operand`, clear `b`, go to ENTER_B.
  - `KEY_EQ` is ignored.
- ENTER_B:
  - Digit → updates `b`.
  - Operator key → replaces `operand` only if no B digit has been entered yet; otherwise it is ignored.
  - `KEY_EQ` → go to CALC.
- CALC:
  - Add: `result` = (a+b)[7:0]; `overflow` = carry out; `sign` = 0.
  - Sub: if a≥b, `result` = a−b and `sign` = 0; otherwise `result` = b−a and `sign` = 1. `overflow` = 0.
  - Mul: `result` = product[7:0]; `overflow` = OR of product[15:8]; `sign` = 0.
  - Every key is dropped while in CALC, except `KEY_CLR`.
  - On completion → DONE.
- DONE:
  - Digit → clear all outputs to their reset values, set `a` = digit, go to ENTER_A.
  - Operator key → chaining. Only if `sign`=0 and `overflow`=0: `a` = result, `b` = 0, clear `result`, latch operator, go to ENTER_B. Otherwise the key is ignored.
  - `KEY_EQ` is ignored.
- `KEY_CLR`, in any state including mid-CALC → all outputs take their reset values and state returns to ENTER_A on the next edge. An in-flight multiply is aborted.
- Unknown key codes are ignored everywhere.

## Timing
- `key_valid` is sampled at a clock edge; the entry updates take effect at that same edge.
- `KEY_EQ` sampled at edge N → state is CALC and `busy`=1 from edge N+1.
- Add/Sub: `result`, `sign` and `overflow` update at edge N+2, with state DONE and `busy`=0.
- Mul: the multiplier starts at edge N+1 and iterates over edges N+2..N+9. Results register at edge N+10, where `busy` drops.
- `rst` asserted asynchronously clears everything immediately, mid-operation included.

## Configuration
- Macro: `CALC_MUL_EN`.
- Defined: `KEY_MUL` is accepted and the multiplier sub-module is instantiated.
- Undefined: `KEY_MUL` is treated as an unknown key and ignored in all states, and no multiplier logic is built.

## Structure
- Package `calc_pkg` contains:
  - the state enum;
  - key constants: `KEY_ADD`=10, `KEY_SUB`=11, `KEY_MUL`=12, `KEY_EQ`=13, `KEY_CLR`=14;
  - operator glyph constants: `OP_NONE`=8'd128, `OP_SUB`=8'd130, `OP_ADD`=8'd131, `OP_MUL`=8'd132.
- One sub-module, `seq_mult8`:
  - inputs: `start`, plus the two 8-bit multiplicand/multiplier operands;
  - outputs: a 16-bit product and a `done` pulse;
  - 8 iterations, with an abort input.

## Test plan
- Reset, then keys 1,2,3 → `a`=123, `operand`=`OP_NONE`, `result`=0.
- Keys 2,5,6 → `a`=25; the digit 6 is dropped.
- Keys 2,0,0,+,1,0,0,= → `result`=44, `overflow`=1, `sign`=0, valid two edges after `=`.
- Keys 5,−,9,= → `result`=4, `sign`=1. Then `+` → ignored, state stays DONE.
- With `CALC_MUL_EN` defined: keys 1,5,*,1,7,= → `busy` high for 9 cycles, then `result`=255 and `overflow`=0. A digit key pressed during `busy` is dropped. Without the macro, `*` is ignored and `operand` stays `OP_NONE`.
- `KEY_CLR` during a multiply CALC → on the next edge all outputs take their reset values, `busy`=0 and state is ENTER_A.
